oam_dma_ctrl: RTL

// - CPU-side initiator of the sprite OAM DMA. Sits between the CPU bus, work RAM and ppu_toplevel.
// - A CPU write to $4014 (page P) halts the CPU.
// - The block then copies 256 bytes from $P00-$PFF into PPU OAM over oam_dma/oam_addr/oam_data_in.

---
 rtl/oam_dma_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA initiator: a CPU write to DMA_REG_ADDR halts the CPU and copies page P into PPU OAM.
// Optional odd-cycle alignment slot enabled by defining OAM_DMA_ODD_ALIGN_EN.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter int unsigned OAM_BYTES    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_we,
    input  logic [7:0]  oam_base,
    input  logic [7:0]  mem_data_in,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        cpu_halt,
    output logic        oam_dma,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data_out,
    output logic        dma_busy
);

    localparam int unsigned        IDX_W    = $clog2(OAM_BYTES);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(OAM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx;
    logic [7:0]       page;
    logic [7:0]       base;
    logic             trigger;

    assign trigger = (state == S_IDLE) && cpu_we && (cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_ODD_ALIGN_EN
    logic parity;
    logic align_req;

    // Parity is captured on the trigger cycle itself, not re-sampled in HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity    <= 1'b0;
            align_req <= 1'b0;
        end else begin
            parity <= ~parity;
            if (trigger)
                align_req <= parity;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            page  <= '0;
            base  <= '0;
        end else begin
            state <= state_next;
            if (trigger) begin
                page <= cpu_data_in;
                base <= oam_base;
                idx  <= '0;
            end else if (state == S_WRITE && idx != IDX_LAST) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        mem_re       = 1'b0;
        mem_addr     = '0;
        oam_dma      = 1'b0;
        oam_addr     = '0;
        oam_data_out = '0;
        cpu_halt     = 1'b1;
        dma_busy     = 1'b1;
        case (state)
            S_IDLE: begin
                cpu_halt = 1'b0;
                dma_busy = 1'b0;
                if (trigger)
                    state_next = S_HALT;
            end
            S_HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                state_next = align_req ? S_ALIGN : S_READ;
`else
                state_next = S_READ;
`endif
            end
            S_ALIGN: state_next = S_READ;
            S_READ: begin
                mem_re     = 1'b1;
                mem_addr   = {page, 8'(idx)};
                state_next = S_WRITE;
            end
            S_WRITE: begin
                oam_dma      = 1'b1;
                oam_addr     = base + 8'(idx);
                oam_data_out = mem_data_in;
                state_next   = (idx == IDX_LAST) ? S_IDLE : S_READ;
            end
            default: begin
                cpu_halt   = 1'b0;
                dma_busy   = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
